// File: rtl/seg_scan_decoder_if.sv
// Display-bus bundle for seg_scan_decoder: the multiplexed active-low pins
// coming in, and the recovered per-digit state going out.
interface seg_scan_decoder_if #(
  parameter int DIGITS = 4
);
  logic [DIGITS-1:0]   an;           // digit enables, active-low
  logic [6:0]          seg;          // segments a..g, active-low
  logic [4*DIGITS-1:0] digits;       // recovered nibbles, digit i at [4i+3:4i]
  logic [DIGITS-1:0]   digit_valid;
  logic [DIGITS-1:0]   digit_blank;
  logic [DIGITS-1:0]   digit_err;
  logic                upd;          // one-cycle pulse per accepted capture
  logic [2:0]          upd_idx;

  // Display side: drives the pins and observes the decode.
  modport master (
    output an, seg,
    input  digits, digit_valid, digit_blank, digit_err, upd, upd_idx
  );

  // Decoder side.
  modport slave (
    input  an, seg,
    output digits, digit_valid, digit_blank, digit_err, upd, upd_idx
  );
endinterface

// File: rtl/seg_scan_decoder.sv
// Recovers the hex nibble shown on each digit of a multiplexed active-low
// 7-segment bus. Pins are synchronised, a capture is accepted only after the
// sample has been steady for STABLE cycles, and each digit's valid flag
// expires TIMEOUT cycles after its last refresh.
module seg_scan_decoder #(
  parameter int DIGITS  = 4,
  parameter int STABLE  = 4,
  parameter int TIMEOUT = 65535
) (
  input  logic               clk,
  input  logic               rst_n,
  seg_scan_decoder_if.slave  bus
);

  localparam int SW   = $clog2(STABLE + 1);
  localparam int TW   = $clog2(TIMEOUT + 1);
  localparam int SMPW = DIGITS + 7;

  localparam logic [SW-1:0]     CNT_ONE   = SW'(1);
  localparam logic [SW-1:0]     CNT_LAST  = SW'(STABLE - 1);
  localparam logic [TW-1:0]     STALE_ONE = TW'(1);
  localparam logic [TW-1:0]     STALE_MAX = TW'(TIMEOUT);
  localparam logic [DIGITS-1:0] EN_ONE    = DIGITS'(1);

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;
  typedef enum logic [1:0] {K_HEX, K_BLANK, K_ERR} kind_t;
  typedef struct packed {
    kind_t      kind;
    logic [3:0] nib;
  } cap_t;

  function automatic cap_t decode(input logic [6:0] s);
    cap_t c;
    c.kind = K_HEX;
    c.nib  = 4'h0;
    case (s)
      7'b0000001: c.nib = 4'h0;
      7'b1001111: c.nib = 4'h1;
      7'b0010010: c.nib = 4'h2;
      7'b0000110: c.nib = 4'h3;
      7'b1001100: c.nib = 4'h4;
      7'b0100100: c.nib = 4'h5;
      7'b0100000: c.nib = 4'h6;
      7'b0001111: c.nib = 4'h7;
      7'b0000000: c.nib = 4'h8;
      7'b0000100: c.nib = 4'h9;
      7'b0001000: c.nib = 4'hA;
      7'b1100000: c.nib = 4'hB;
      7'b0110001: c.nib = 4'hC;
      7'b1000010: c.nib = 4'hD;
      7'b0110000: c.nib = 4'hE;
      7'b0111000: c.nib = 4'hF;
      7'b1111111: c.kind = K_BLANK;
      default:    c.kind = K_ERR;
    endcase
    return c;
  endfunction

  logic [DIGITS-1:0] an_m_q, an_s_q;
  logic [6:0]        seg_m_q, seg_s_q;
  logic [SMPW-1:0]   prev_q;

  state_t            state_q, state_d;
  logic [SW-1:0]     cnt_q, cnt_d;
  logic              accept;

  logic [DIGITS-1:0][3:0]    digits_q, digits_d;
  logic [DIGITS-1:0]         valid_q, valid_d;
  logic [DIGITS-1:0]         blank_q, blank_d;
  logic [DIGITS-1:0]         err_q, err_d;
  logic [DIGITS-1:0][TW-1:0] stale_q, stale_d;
  logic                      upd_q, upd_d;
  logic [2:0]                upd_idx_q, upd_idx_d;

  logic [DIGITS-1:0] en;
  logic              onehot;
  logic              changed;
  logic [2:0]        sel;
  cap_t              cap;

  assign en      = ~an_s_q;
  assign onehot  = (en != '0) && ((en & (en - EN_ONE)) == '0);
  assign changed = {an_s_q, seg_s_q} != prev_q;
  assign cap     = decode(seg_s_q);

  // Index of the enabled digit (meaningful only while onehot is set).
  always_comb begin
    sel = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!an_s_q[i]) sel = 3'(i);
    end
  end

  // Input synchronisers and a one-cycle-old copy of the synchronised sample.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous, so it is only seen inside the clocked branch.
    if (!rst_n) begin
      an_m_q  <= '1;
      an_s_q  <= '1;
      seg_m_q <= '1;
      seg_s_q <= '1;
      prev_q  <= '1;
    end else begin
      // NOTE: non-blocking everywhere in clocked logic so each stage takes the pre-edge value.
      an_m_q  <= bus.an;
      an_s_q  <= an_m_q;
      seg_m_q <= bus.seg;
      seg_s_q <= seg_m_q;
      prev_q  <= {an_s_q, seg_s_q};
    end
  end

  // Capture FSM state and stability counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Capture FSM: a change always restarts settling, even on the would-be accept cycle.
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (onehot) state_d = SETTLE;
      end
      SETTLE: begin
        if (changed || !onehot) begin
          cnt_d   = '0;
          state_d = onehot ? SETTLE : IDLE;
        end else if (cnt_q == CNT_LAST) begin
          accept  = 1'b1;
          cnt_d   = '0;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HOLD: begin
        if (changed) state_d = onehot ? SETTLE : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Per-digit results and stale counters; an accepted capture overrides expiry.
  always_comb begin
    digits_d  = digits_q;
    valid_d   = valid_q;
    blank_d   = blank_q;
    err_d     = err_q;
    stale_d   = stale_q;
    upd_d     = accept;
    upd_idx_d = accept ? sel : upd_idx_q;
    for (int i = 0; i < DIGITS; i++) begin
      stale_d[i] = (stale_q[i] == STALE_MAX) ? stale_q[i] : stale_q[i] + STALE_ONE;
      if (stale_d[i] == STALE_MAX) valid_d[i] = 1'b0;
      if (accept && (sel == 3'(i))) begin
        stale_d[i] = '0;
        valid_d[i] = (cap.kind == K_HEX);
        blank_d[i] = (cap.kind == K_BLANK);
        err_d[i]   = (cap.kind == K_ERR);
        if (cap.kind == K_HEX) digits_d[i] = cap.nib;
      end
    end
  end

  // Registered outputs, all updating on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      digits_q  <= '0;
      valid_q   <= '0;
      blank_q   <= '0;
      err_q     <= '0;
      stale_q   <= '0;
      upd_q     <= 1'b0;
      upd_idx_q <= '0;
    end else begin
      digits_q  <= digits_d;
      valid_q   <= valid_d;
      blank_q   <= blank_d;
      err_q     <= err_d;
      stale_q   <= stale_d;
      upd_q     <= upd_d;
      upd_idx_q <= upd_idx_d;
    end
  end

  assign bus.digits      = digits_q;
  assign bus.digit_valid = valid_q;
  assign bus.digit_blank = blank_q;
  assign bus.digit_err   = err_q;
  assign bus.upd         = upd_q;
  assign bus.upd_idx     = upd_idx_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench for seg_scan_decoder: each steady pattern driven pushes its
// expected capture; the upd monitor pops and compares it, including latency.
module tb_seg_scan_decoder;

  localparam int DIGITS  = 4;
  localparam int STABLE  = 4;
  localparam int TIMEOUT = 50;
  localparam int LAT     = STABLE + 2;

  typedef enum logic [1:0] {K_HEX, K_BLANK, K_ERR} kind_t;
  typedef struct {
    logic [2:0] idx;
    kind_t      kind;
    logic [3:0] nib;
    int         due;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg_scan_decoder_if #(.DIGITS(DIGITS)) bus ();

  seg_scan_decoder #(
    .DIGITS (DIGITS),
    .STABLE (STABLE),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int upd_cnt = 0;
  int last_upd_cyc = 0;

  exp_t       sb [$];
  logic [3:0] model [DIGITS];

  logic [6:0] pat [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };
  logic [6:0] scan_pat [4] = '{7'b0010010, 7'b0001000, 7'b1000010, 7'b0000001};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic exp_t expect_for(input logic [DIGITS-1:0] an, input logic [6:0] s);
    exp_t e;
    e.idx  = 3'd0;
    e.kind = K_ERR;
    e.nib  = 4'h0;
    for (int i = 0; i < DIGITS; i++) if (!an[i]) e.idx = 3'(i);
    if (s == 7'b1111111) e.kind = K_BLANK;
    for (int k = 0; k < 16; k++) begin
      if (pat[k] == s) begin
        e.kind = K_HEX;
        e.nib  = 4'(k);
      end
    end
    e.due = cyc + 1 + LAT;
    return e;
  endfunction

  // Monitor: every upd pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && bus.upd) begin
      exp_t e;
      upd_cnt++;
      last_upd_cyc = cyc;
      if (sb.size() == 0) begin
        check("spurious_upd", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("upd_idx", 32'(bus.upd_idx), 32'(e.idx));
        check("latency", 32'(cyc), 32'(e.due));
        if (e.kind == K_HEX) model[e.idx] = e.nib;
        check("cap_digit", 32'(bus.digits[4*e.idx +: 4]), 32'(model[e.idx]));
        check("cap_valid", 32'(bus.digit_valid[e.idx]), 32'(e.kind == K_HEX));
        check("cap_blank", 32'(bus.digit_blank[e.idx]), 32'(e.kind == K_BLANK));
        check("cap_err",   32'(bus.digit_err[e.idx]),   32'(e.kind == K_ERR));
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) step();
  endtask

  task automatic drive(input logic [DIGITS-1:0] an, input logic [6:0] s, input bit expect_cap);
    bus.an  = an;
    bus.seg = s;
    if (expect_cap) sb.push_back(expect_for(an, s));
  endtask

  task automatic wait_drain(input int budget);
    int t = 0;
    while (sb.size() != 0 && t < budget) begin
      step();
      t++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_digits"}, 32'(bus.digits), 32'd0);
    check({tag, "_valid"},  32'(bus.digit_valid), 32'd0);
    check({tag, "_blank"},  32'(bus.digit_blank), 32'd0);
    check({tag, "_err"},    32'(bus.digit_err), 32'd0);
    check({tag, "_upd"},    32'(bus.upd), 32'd0);
    check({tag, "_upd_idx"}, 32'(bus.upd_idx), 32'd0);
  endtask

  initial begin
    int base;
    int cap;
    int t;
    logic [DIGITS-1:0] a;
    logic [4*DIGITS-1:0] snap_digits;
    logic [DIGITS-1:0] snap_blank, snap_err;

    bus.an  = '1;
    bus.seg = '1;
    for (int i = 0; i < DIGITS; i++) model[i] = 4'h0;

    // Reset state
    wait_cycles(3);
    check_all_zero("rst");
    rst_n = 1'b1;
    step();

    // Single steady digit: one capture, one pulse
    base = upd_cnt;
    drive(4'b1110, 7'b0010010, 1'b1);
    wait_drain(20);
    check("t1_digit0", 32'(bus.digits[3:0]), 32'h2);
    check("t1_valid0", 32'(bus.digit_valid[0]), 32'd1);
    wait_cycles(20);
    check("t1_single_upd", 32'(upd_cnt - base), 32'd1);

    // Scan all four digits
    drive('1, '1, 1'b0);
    wait_cycles(4);
    base = upd_cnt;
    for (int i = 0; i < DIGITS; i++) begin
      a    = '1;
      a[i] = 1'b0;
      drive(a, scan_pat[i], 1'b1);
      wait_cycles(12);
    end
    wait_drain(20);
    check("scan_digits", 32'(bus.digits), 32'h0DA2);
    check("scan_valid",  32'(bus.digit_valid), 32'hF);
    check("scan_upds",   32'(upd_cnt - base), 32'd4);

    // Blank then illegal pattern on digit 1
    drive(4'b1101, 7'b1111111, 1'b1);
    wait_drain(20);
    check("blank_b1",  32'(bus.digit_blank[1]), 32'd1);
    check("blank_v1",  32'(bus.digit_valid[1]), 32'd0);
    check("blank_d1",  32'(bus.digits[7:4]), 32'hA);
    drive(4'b1101, 7'b1010101, 1'b1);
    wait_drain(20);
    check("err_e1", 32'(bus.digit_err[1]), 32'd1);
    check("err_b1", 32'(bus.digit_blank[1]), 32'd0);
    check("err_d1", 32'(bus.digits[7:4]), 32'hA);

    // Two enables low, then a short segment glitch: nothing captured
    drive(4'b1100, 7'b1010101, 1'b0);
    wait_cycles(10);
    snap_digits = bus.digits;
    snap_blank  = bus.digit_blank;
    snap_err    = bus.digit_err;
    base        = upd_cnt;
    drive(4'b1100, 7'b0000000, 1'b0);
    wait_cycles(3);
    drive(4'b1100, 7'b1010101, 1'b0);
    wait_cycles(12);
    check("glitch_upds",   32'(upd_cnt - base), 32'd0);
    check("glitch_digits", 32'(bus.digits), 32'(snap_digits));
    check("glitch_blank",  32'(bus.digit_blank), 32'(snap_blank));
    check("glitch_err",    32'(bus.digit_err), 32'(snap_err));

    // Staleness on digit 2
    drive(4'b1011, 7'b0001111, 1'b1);
    wait_drain(20);
    cap = last_upd_cyc;
    drive('1, '1, 1'b0);
    t = 0;
    while (cyc < cap + TIMEOUT - 1 && t < 200) begin
      step();
      t++;
    end
    check("stale_reached", 32'(cyc), 32'(cap + TIMEOUT - 1));
    check("stale_before", 32'(bus.digit_valid[2]), 32'd1);
    step();
    check("stale_after",  32'(bus.digit_valid[2]), 32'd0);
    check("stale_digit2", 32'(bus.digits[11:8]), 32'h7);

    // Reset in the middle of settling
    wait_cycles(4);
    drive(4'b1011, 7'b0100100, 1'b0);
    wait_cycles(5);
    rst_n = 1'b0;
    for (int i = 0; i < DIGITS; i++) model[i] = 4'h0;
    step();
    check_all_zero("midrst");
    wait_cycles(2);
    rst_n = 1'b1;
    base  = upd_cnt;
    drive(4'b1011, 7'b0100100, 1'b1);
    wait_drain(20);
    check("post_rst_digits", 32'(bus.digits), 32'h0500);
    check("post_rst_valid",  32'(bus.digit_valid), 32'h4);
    wait_cycles(20);
    check("post_rst_upds", 32'(upd_cnt - base), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
